// File: rtl/color_calc_pkg.sv
// Shared types and constants for the per-bin colour stage.
package CCHW;

  localparam int W = 6;
  localparam int D = 10;

  // Hue anchors on a D-bit colour wheel (0 = red)
  localparam int HUE_YELLOW = 171;
  localparam int HUE_T1     = 341;
  localparam int HUE_T2     = 683;

  typedef struct packed {
    logic [W+D-1:0] position;
    logic [W+D-1:0] amplitude;
    logic [W+D-1:0] amplitude_fast;
  } Note;

endpackage

// File: rtl/color_calc_hue.sv
// Hue path: note position -> fraction of octave (S1) -> hue on the colour wheel (S2).
module hue_calc
  import CCHW::*;
#(
  parameter int W               = CCHW::W,
  parameter int D               = CCHW::D,
  parameter int BINS_PER_OCTAVE = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W+D-1:0] position,
  output logic [D-1:0] hue
);

  // Rounded reciprocal of the octave length, in D fraction bits
  localparam int RECIP = ((1 << D) + BINS_PER_OCTAVE / 2) / BINS_PER_OCTAVE;
  localparam int PW    = W + 2 * D + 1;

  logic [PW-1:0] pos_prod;
  logic [D-1:0]  p_next;
  logic [D-1:0]  p_s1;
  logic [D-1:0]  hue_next;
  int            p_int;

  // Positions past one octave wrap by dropping the integer part of p
  assign pos_prod = PW'(position) * PW'(RECIP);
  assign p_next   = D'(pos_prod >> D);
  assign p_int    = int'(p_s1);

  // Piecewise hue map: yellow->red, red->blue (through wrap), blue->yellow-ish
  always_comb begin
    hue_next = '0;
    if (p_int < HUE_T1)
      hue_next = D'(HUE_YELLOW - p_int / 2);
    else if (p_int < HUE_T2)
      hue_next = D'((1 << D) - (p_int - HUE_T1));
    else
      hue_next = D'(HUE_T2 - (3 * (p_int - HUE_T2)) / 2);
  end

  // S1/S2 registers of the hue path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_s1 <= '0;
      hue  <= '0;
    end else begin
      p_s1 <= p_next;
      hue  <= hue_next;
    end
  end

endmodule

// File: rtl/color_calc.sv
// Per-bin colour stage: position + amplitudes -> 24-bit RGB, fixed pipeline.
// Build option: CCHW_STEADY_BRIGHT_EN forces full brightness for every bin above the floor.
module color_calc
  import CCHW::*;
#(
  parameter int W                   = CCHW::W,
  parameter int D                   = CCHW::D,
  parameter int BINS_PER_OCTAVE     = 24,
  parameter int SaturationAmplifier = 1638,
  parameter int LEDLimit            = 1023,
  parameter int LEDFloor            = 102
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W+D-1:0] notePosition_i,
  input  logic [W+D-1:0] noteAmplitude_i,
  input  logic [W+D-1:0] noteAmplitudeFast_i,
  output logic [23:0]    rgb,
  output logic           data_v
);

  localparam int FW = W + D;
  localparam int HW = D + 3;

  logic           vld_in, vld_s1, vld_s2, vld_s3;
  logic [FW-1:0]  pos_in, amp_in, amp_s1;
  logic [D-1:0]   hue_s2;
  logic [D-1:0]   bright_next, bright_s2;
  logic [HW-1:0]  hue6;
  logic [2:0]     sector_s3;
  logic [D-1:0]   frac_s3;
  logic [7:0]     v8_s3;
  logic [D+7:0]   rise_prod;
  logic [7:0]     rise, fall;
  logic [23:0]    rgb_next;

  hue_calc #(
    .W               (W),
    .D               (D),
    .BINS_PER_OCTAVE (BINS_PER_OCTAVE)
  ) u_hue (
    .clk      (clk),
    .rst      (rst),
    .position (pos_in),
    .hue      (hue_s2)
  );

`ifdef CCHW_STEADY_BRIGHT_EN
  // Brightness is a fixed level; only the floor test on the slow amplitude matters
  always_comb begin
    bright_next = D'(LEDLimit);
    if (amp_s1 < FW'(LEDFloor)) bright_next = '0;
  end
`else
  localparam int PW = 2 * FW;
  logic [FW-1:0] fast_in, fast_s1;
  logic [PW-1:0] gain_prod, gain_shift;

  assign gain_prod  = PW'(fast_s1) * PW'(SaturationAmplifier);
  assign gain_shift = gain_prod >> D;

  // Amplified fast amplitude, clamped, gated by the slow-amplitude floor
  always_comb begin
    bright_next = D'(LEDLimit);
    if (gain_shift < PW'(LEDLimit)) bright_next = D'(gain_shift);
    if (amp_s1 < FW'(LEDFloor)) bright_next = '0;
  end

  // Fast amplitude travels alongside the slow one until S2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fast_in <= '0;
      fast_s1 <= '0;
    end else begin
      fast_in <= noteAmplitudeFast_i;
      fast_s1 <= fast_in;
    end
  end
`endif

  assign hue6 = HW'(hue_s2) * HW'(6);

  assign rise_prod = (D + 8)'(v8_s3) * (D + 8)'(frac_s3);
  assign rise      = 8'(rise_prod >> D);
  assign fall      = v8_s3 - rise;

  // HSV->RGB with full saturation; sectors 6/7 cannot occur
  always_comb begin
    rgb_next = '0;
    case (sector_s3)
      3'd0:    rgb_next = {v8_s3, rise,  8'd0};
      3'd1:    rgb_next = {fall,  v8_s3, 8'd0};
      3'd2:    rgb_next = {8'd0,  v8_s3, rise};
      3'd3:    rgb_next = {8'd0,  fall,  v8_s3};
      3'd4:    rgb_next = {rise,  8'd0,  v8_s3};
      3'd5:    rgb_next = {v8_s3, 8'd0,  fall};
      default: rgb_next = '0;
    endcase
  end

  // Input capture, brightness/sector stages and valid shift chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_in    <= 1'b0;
      vld_s1    <= 1'b0;
      vld_s2    <= 1'b0;
      vld_s3    <= 1'b0;
      pos_in    <= '0;
      amp_in    <= '0;
      amp_s1    <= '0;
      bright_s2 <= '0;
      sector_s3 <= '0;
      frac_s3   <= '0;
      v8_s3     <= '0;
    end else begin
      vld_in    <= start;
      vld_s1    <= vld_in;
      vld_s2    <= vld_s1;
      vld_s3    <= vld_s2;
      pos_in    <= notePosition_i;
      amp_in    <= noteAmplitude_i;
      amp_s1    <= amp_in;
      bright_s2 <= bright_next;
      sector_s3 <= hue6[HW-1:D];
      frac_s3   <= hue6[D-1:0];
      v8_s3     <= bright_s2[D-1:D-8];
    end
  end

  // Output stage: rgb updates only with a valid sample and holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb    <= '0;
      data_v <= 1'b0;
    end else begin
      data_v <= vld_s3;
      if (vld_s3) rgb <= rgb_next;
    end
  end

endmodule

// File: tb/tb_color_calc.sv
// Self-checking bench for color_calc: directed cases plus randomized traffic
// against an arithmetic reference model and an expected-output queue.
module tb_color_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] notePosition_i = '0;
  logic [15:0] noteAmplitude_i = '0;
  logic [15:0] noteAmplitudeFast_i = '0;
  logic [23:0] rgb;
  logic        data_v;

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] last_rgb = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  color_calc dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .notePosition_i      (notePosition_i),
    .noteAmplitude_i     (noteAmplitude_i),
    .noteAmplitudeFast_i (noteAmplitudeFast_i),
    .rgb                 (rgb),
    .data_v              (data_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] model_rgb(int pos, int slow, int fast);
    int p, hue, v, v8, h6, sector, f, rise, fall, r, g, b;
    p = ((pos * 43) / 1024) % 1024;
    if (p < 341)      hue = 171 - p / 2;
    else if (p < 683) hue = (1024 - (p - 341)) % 1024;
    else              hue = 683 - (3 * (p - 683)) / 2;
`ifdef CCHW_STEADY_BRIGHT_EN
    v = 1023;
`else
    v = (fast * 1638) / 1024;
    if (v > 1023) v = 1023;
`endif
    if (slow < 102) v = 0;
    v8     = v / 4;
    h6     = hue * 6;
    sector = h6 / 1024;
    f      = h6 % 1024;
    rise   = (v8 * f) / 1024;
    fall   = v8 - rise;
    r = 0; g = 0; b = 0;
    case (sector)
      0: begin r = v8;   g = rise; end
      1: begin r = fall; g = v8;   end
      2: begin g = v8;   b = rise; end
      3: begin g = fall; b = v8;   end
      4: begin r = rise; b = v8;   end
      default: begin r = v8; b = fall; end
    endcase
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // One cycle: wait to the falling edge, then compare outputs against the queue
  task automatic step();
    logic exp_dv;
    @(negedge clk);
    exp_dv = (sb.size() > 0) && (sb[0].due == cyc);
    check_val("data_v", 32'(data_v), 32'(exp_dv));
    if (exp_dv) begin
      last_rgb = sb[0].rgb;
      void'(sb.pop_front());
    end
    check_val("rgb", 32'(rgb), 32'(last_rgb));
  endtask

  task automatic send(input int pos, input int slow, input int fast, input logic [23:0] exp);
    exp_t e;
    start               = 1'b1;
    notePosition_i      = 16'(pos);
    noteAmplitude_i     = 16'(slow);
    noteAmplitudeFast_i = 16'(fast);
    e.rgb = exp;
    e.due = cyc + 5;
    sb.push_back(e);
  endtask

  task automatic send_model(input int pos, input int slow, input int fast);
    send(pos, slow, fast, model_rgb(pos, slow, fast));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    int pos, slow, fast;

    // reset state
    idle(3);
    rst = 1'b1;
    idle(2);

    // directed cases with hand-derived colours
    step(); send(0, 1024, 1024, 24'hFFFF00);
    step(); start = 1'b0;
    step(); start = 1'b0;
    step(); start = 1'b0;
    step(); start = 1'b0;
    step(); start = 1'b0;
    step(); send(8192, 1024, 1024, 24'hFF0005);
    step(); send(16384, 1024, 1024, 24'h000AFF);
`ifdef CCHW_STEADY_BRIGHT_EN
    step(); send(0, 1024, 256, 24'hFFFF00);
    step(); send(0, 1024, 0, 24'hFFFF00);
`else
    step(); send(0, 1024, 256, 24'h666600);
    step(); send(0, 1024, 0, 24'h000000);
`endif
    step(); send(0, 51, 1024, 24'h000000);
    step(); send(0, 101, 1024, 24'h000000);
    step(); send(0, 102, 1024, 24'hFFFF00);
    idle(8);

    // reset mid-flight discards everything in the pipe
    step(); send(0, 1024, 1024, 24'hFFFF00);
    step(); send(8192, 1024, 1024, 24'hFF0005);
    step(); send(16384, 1024, 1024, 24'h000AFF);
    step();
    start = 1'b0;
    rst   = 1'b0;
    sb.delete();
    last_rgb = '0;
    idle(2);
    rst = 1'b1;
    idle(8);
    step(); send(16384, 1024, 1024, 24'h000AFF);
    idle(8);

    // randomized traffic, including back-to-back bursts and boundary amplitudes
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 3) != 0) begin
        pos  = $urandom_range(0, 65535);
        slow = ($urandom_range(0, 3) == 0) ? $urandom_range(90, 110) : $urandom_range(0, 65535);
        fast = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 800);
        send_model(pos, slow, fast);
      end else begin
        start = 1'b0;
      end
    end

    // sweep one octave and a bit past it to hit every hue threshold
    for (int i = 0; i < 26 * 1024; i += 97) begin
      step();
      send_model(i, 1024, 1024);
    end
    idle(10);

    check_val("drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/color_calc.md
# color_calc

Per-bin colour stage of the linear visualizer. It takes one note's position, its slow amplitude and its fast amplitude, and produces a 24-bit RGB colour through a fixed 4-stage pipeline. One instance exists per bin; the amplitude preprocessor (upstream) and the LED-count stage (parallel) are separate blocks. Hue derivation lives in the `hue_calc` sub-module.

## Interface
- `W`, 6: integer bits of fixed-point values.
- `D`, 10: fraction bits of fixed-point values.
- `BINS_PER_OCTAVE`, 24: bins per octave; note position wraps modulo this.
- `SaturationAmplifier`, 1638: brightness gain, W.D (≈1.6).
- `LEDLimit`, 1023: brightness clamp, D-bit fraction (≈1.0).
- `LEDFloor`, 102: minimum slow amplitude for a lit bin, W.D (≈0.1).
- `clk` in 1: the single clock.
- `rst` in 1: reset. **Reset is asynchronous and active-low.**
- `start` in 1: input-valid strobe; inputs are sampled on every cycle where it is high.
- `notePosition_i` in W+D: note position in bins, unsigned W.D.
- `noteAmplitude_i` in W+D: slow amplitude, W.D.
- `noteAmplitudeFast_i` in W+D: fast amplitude, W.D.
- `rgb` out 24: colour as {R[23:16], G[15:8], B[7:0]}.
- `data_v` out 1: one-cycle pulse marking the cycle in which `rgb` is updated.

## Operation
- **Fraction of octave `p` (D bits).** Let RECIP = round(2^D / BINS_PER_OCTAVE), which is 43 for the defaults. Then p = low D bits of ((notePosition_i × RECIP) >> D).
- **Hue (D-bit fraction of the colour wheel; 0 = red, 171 = yellow, 683 = blue).** Thresholds are T1 = round(2^D/3) and T2 = round(2^(D+1)/3), i.e. 341 and 683.
  - p < T1: hue = 171 − p/2.
  - T1 ≤ p < T2: hue = (2^D − (p − T1)) mod 2^D.
  - p ≥ T2: hue = 683 − (3·(p − T2))/2.
  - All divisions truncate.
- **Brightness V.** V = min((noteAmplitudeFast_i × SaturationAmplifier) >> D, LEDLimit).
  - If noteAmplitude_i < LEDFloor, V = 0.
  - V8 = V >> (D − 8).
- **HSV→RGB with saturation 1.**
  - h6 = hue × 6.
  - sector = h6 >> D, in 0..5.
  - f = low D bits of h6.
  - rise = (V8·f) >> D; fall = V8 − rise.
  - Channel assignment by sector:
    - 0: R = V8, G = rise, B = 0.
    - 1: R = fall, G = V8, B = 0.
    - 2: R = 0, G = V8, B = rise.
    - 3: R = 0, G = fall, B = V8.
    - 4: R = rise, G = 0, B = V8.
    - 5: R = V8, G = 0, B = fall.
- All arithmetic is unsigned. Products are kept at full width before shifting and clamping, so nothing overflows.

## Timing
- There is no state machine. The block is a 4-stage valid pipeline:
  - S1: input registers and p.
  - S2: hue and V.
  - S3: sector, f and V8.
  - S4: rgb.
- Latency: `start` sampled at edge N gives `rgb` and `data_v` at edge N+4.
- Throughput is 1 per cycle. Back-to-back `start` strobes produce back-to-back `data_v` pulses, in order.
- `rgb` holds its last value between pulses. `data_v` is high for exactly one cycle per accepted `start`.
- Reset values: `rgb` = 0, `data_v` = 0, all stage-valid bits cleared.
- Reset asserted mid-flight discards all in-flight samples; no `data_v` pulse follows for them.
- A position of BINS_PER_OCTAVE or more wraps naturally through the low D bits of p.

## Configuration
- `CCHW_STEADY_BRIGHT_EN` defined: V = LEDLimit for every bin whose noteAmplitude_i ≥ LEDFloor. The fast amplitude is ignored.
- Not defined: V is computed from the fast amplitude as described in Operation.

## Structure
- Shared package `CCHW`:
  - the `Note` typedef;
  - default W and D;
  - hue anchor constants (171, 341, 683).
- Sub-module `hue_calc`: maps position to p and then to hue; S1–S2 logic for the hue path.
- `color_calc` holds the brightness path and the HSV→RGB stages.

## Test plan
All cases use default parameters.
- Position 0, slow amplitude 1.0 (1024), fast amplitude 1.0 → `rgb` = 0xFFFF00, `data_v` pulses 4 cycles after `start`.
- Position 8.0 (8192), amplitudes 1.0 → R = 0xFF, G = 0x00, B ≤ 0x08 (red).
- Position 16.0 (16384), amplitudes 1.0 → `rgb` = 0x000AFF.
- Position 0, fast amplitude 0.25 (256) → `rgb` = 0x666600.
- Slow amplitude 0.05 (51) → `rgb` = 0x000000. With `CCHW_STEADY_BRIGHT_EN` and fast amplitude 0 → 0xFFFF00 when the slow amplitude is 1.0.
- Three consecutive `start` cycles, then `rst` low at cycle 2 → no `data_v` pulses and `rgb` = 0. A later single `start` works normally.
